input_conditioner: RTL and testbench

- Front-end stage between the raw 12-bit pad inputs and the Connect4 game core.
- Synchronizes and debounces every button line, produces clean levels and one-cycle press pulses, and encodes the seven column buttons into a column index.
- The game core consumes only these outputs and never sees the raw pads.
- Bit map of raw_in: [6:0] column buttons 0..6, [7] confirm, [8] switch player, [9] switch PvP, [10] new game, [11] debug mode.

---
 rtl/input_conditioner.sv | 79 +++++++
 tb/tb_input_conditioner.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Pad front end for the Connect4 core: 2-flop sync, per-bit debounce, rise pulses
// and one-hot column encoding of the seven column buttons.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] raw_in,
    output logic [11:0] level,
    output logic [11:0] rise,
    output logic [2:0]  move_col,
    output logic        move_valid,
    output logic        move_conflict
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [11:0]      sync1;
    logic [11:0]      sync2;
    logic [CNT_W-1:0] cnt [12];
    logic [11:0]      term;
    logic [11:0]      level_nxt;
    logic [2:0]       col_ones;
    logic [2:0]       col_idx;
    logic             col_press;

    always_comb begin
        term = '0;
        for (int i = 0; i < 12; i++) begin
            term[i] = (sync2[i] != level[i]) && (cnt[i] == CNT_LAST);
        end
        level_nxt = level ^ term;
    end

    // Encoder looks at next-state levels so it lines up with the rise pulse.
    always_comb begin
        col_ones = '0;
        col_idx  = '0;
        for (int i = 0; i < 7; i++) begin
            col_ones = col_ones + 3'(level_nxt[i]);
            if (level_nxt[i]) col_idx = 3'(i);
        end
        col_press = |(level_nxt[6:0] & ~level[6:0]);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1         <= '0;
            sync2         <= '0;
            for (int i = 0; i < 12; i++) cnt[i] <= '0;
            level         <= '0;
            rise          <= '0;
            move_col      <= 3'd7;
            move_valid    <= 1'b0;
            move_conflict <= 1'b0;
        end else begin
            sync1 <= raw_in;
            sync2 <= sync1;
            for (int i = 0; i < 12; i++) begin
                if (sync2[i] == level[i] || term[i]) cnt[i] <= '0;
                else                                 cnt[i] <= cnt[i] + 1'b1;
            end
            level         <= level_nxt;
            rise          <= level_nxt & ~level;
            move_valid    <= 1'b0;
            move_conflict <= 1'b0;
            if (col_press) begin
                if (col_ones == 3'd1) begin
                    move_col   <= col_idx;
                    move_valid <= 1'b1;
                end else if (col_ones > 3'd1) begin
                    move_conflict <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random pad activity,
// all checked against a sliding-window reference model.
module tb_input_conditioner;

    localparam int D = 4;

    logic        clock;
    logic        reset;
    logic [11:0] raw_in;
    logic [11:0] level;
    logic [11:0] rise;
    logic [2:0]  move_col;
    logic        move_valid;
    logic        move_conflict;

    input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clock(clock), .reset(reset), .raw_in(raw_in),
        .level(level), .rise(rise), .move_col(move_col),
        .move_valid(move_valid), .move_conflict(move_conflict)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [11:0] m_s1, m_s2, m_level, m_rise;
    logic [2:0]  m_col;
    logic        m_valid, m_conf;
    logic [11:0] hist[$];

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0;
        m_col = 3'd7; m_valid = 1'b0; m_conf = 1'b0;
        hist.delete();
    endtask

    // A bit flips once its last D synchronized samples all disagree with its level.
    task automatic model_step();
        logic [11:0] nxt;
        int          ones;
        int          idx;
        bit          all_diff;
        if (!reset) begin
            model_reset();
            return;
        end
        hist.push_back(m_s2);
        if (hist.size() > D) void'(hist.pop_front());
        nxt = m_level;
        if (hist.size() == D) begin
            for (int i = 0; i < 12; i++) begin
                all_diff = 1'b1;
                foreach (hist[j]) if (hist[j][i] == m_level[i]) all_diff = 1'b0;
                if (all_diff) nxt[i] = ~m_level[i];
            end
        end
        m_rise  = nxt & ~m_level;
        m_valid = 1'b0;
        m_conf  = 1'b0;
        if (m_rise[6:0] != 7'd0) begin
            ones = $countones(nxt[6:0]);
            idx  = 0;
            for (int i = 0; i < 7; i++) if (nxt[i]) idx = i;
            if (ones == 1) begin
                m_valid = 1'b1;
                m_col   = 3'(idx);
            end else if (ones > 1) begin
                m_conf = 1'b1;
            end
        end
        m_level = nxt;
        m_s2    = m_s1;
        m_s1    = raw_in;
    endtask

    task automatic compare_all();
        check_val("level", int'(level), int'(m_level));
        check_val("rise", int'(rise), int'(m_rise));
        check_val("move_col", int'(move_col), int'(m_col));
        check_val("move_valid", int'(move_valid), int'(m_valid));
        check_val("move_conflict", int'(move_conflict), int'(m_conf));
    endtask

    task automatic step(input logic [11:0] v, input logic rst);
        @(negedge clock);
        raw_in = v;
        reset  = rst;
        if (!rst) model_reset();
        @(posedge clock);
        model_step();
        #1;
        compare_all();
    endtask

    int first, cnt_a, cnt_b;
    logic [11:0] rv;

    initial begin
        raw_in = 12'hFFF;
        reset  = 1'b0;
        model_reset();

        // reset held with all pads active
        for (int k = 0; k < 10; k++) step(12'hFFF, 1'b0);
        for (int k = 0; k < 4; k++) step(12'h000, 1'b1);

        // confirm press, held 20 cycles, then released
        first = 0; cnt_a = 0;
        for (int k = 1; k <= 20; k++) begin
            step(12'h080, 1'b1);
            if (level[7] && first == 0) first = k;
            cnt_a += int'(rise[7]);
        end
        check_val("confirm_rise_edge", first, 6);
        check_val("confirm_pulses", cnt_a, 1);
        first = 0; cnt_a = 0;
        for (int k = 1; k <= 12; k++) begin
            step(12'h000, 1'b1);
            if (!level[7] && first == 0) first = k;
            cnt_a += int'(rise[7]);
        end
        check_val("confirm_fall_edge", first, 6);
        check_val("confirm_release_pulses", cnt_a, 0);

        // 3-cycle glitch on column 3
        cnt_a = 0; cnt_b = 0;
        for (int k = 1; k <= 15; k++) begin
            step((k <= 3) ? 12'h008 : 12'h000, 1'b1);
            cnt_a += int'(rise[3]) + int'(level[3]);
            cnt_b += int'(move_valid);
        end
        check_val("glitch_activity", cnt_a, 0);
        check_val("glitch_valid", cnt_b, 0);

        // bouncing switch-player line, settles high at cycle 9
        first = 0; cnt_a = 0;
        for (int k = 1; k <= 20; k++) begin
            step((((k - 1) / 2) % 2 == 0 || k > 10) ? 12'h100 : 12'h000, 1'b1);
            if (level[8] && first == 0) first = k;
            cnt_a += int'(rise[8]);
        end
        check_val("bounce_rise_edge", first, 14);
        check_val("bounce_pulses", cnt_a, 1);
        for (int k = 0; k < 8; k++) step(12'h000, 1'b1);

        // column 2, then 5 on top, then release and column 6
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            step(12'h004, 1'b1);
            cnt_a += int'(move_valid);
            cnt_b += int'(move_valid && rise[2]);
        end
        check_val("col2_valid_pulses", cnt_a, 1);
        check_val("col2_coincident", cnt_b, 1);
        check_val("col2_value", int'(move_col), 2);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            step(12'h024, 1'b1);
            cnt_a += int'(move_conflict);
            cnt_b += int'(move_valid);
        end
        check_val("conflict_pulses", cnt_a, 1);
        check_val("conflict_no_valid", cnt_b, 0);
        check_val("conflict_col_hold", int'(move_col), 2);
        for (int k = 0; k < 10; k++) step(12'h000, 1'b1);
        check_val("col_held_after_release", int'(move_col), 2);
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            step(12'h040, 1'b1);
            cnt_a += int'(move_valid);
        end
        check_val("col6_valid_pulses", cnt_a, 1);
        check_val("col6_value", int'(move_col), 6);

        // asynchronous reset between edges
        @(negedge clock);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_val("async_level", int'(level), 0);
        check_val("async_col", int'(move_col), 7);
        compare_all();
        for (int k = 0; k < 2; k++) step(12'h000, 1'b0);
        for (int k = 0; k < 4; k++) step(12'h000, 1'b1);

        // new-game held, reset pulse at the fourth edge restarts the count
        for (int k = 1; k <= 3; k++) step(12'h400, 1'b1);
        step(12'h400, 1'b0);
        first = 0; cnt_a = 0;
        for (int k = 1; k <= 10; k++) begin
            step(12'h400, 1'b1);
            if (k == 2) check_val("midreset_no_change_e6", int'(level[10]), 0);
            if (level[10] && first == 0) first = k;
            cnt_a += int'(rise[10]);
        end
        check_val("midreset_rise_edge", first, 6);
        check_val("midreset_pulses", cnt_a, 1);

        // random pad activity with rare reset pulses
        rv = 12'h000;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 12; b++)
                if ($urandom_range(7) == 0) rv[b] = ~rv[b];
            step(rv, ($urandom_range(499) == 0) ? 1'b0 : 1'b1);
            if (move_valid && move_conflict) check_val("valid_conflict_exclusive", 1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
